// File: rtl/final_add_arbiter.sv
// Two-requester arbiter in front of a shared carry-chain adder with a one-entry result register.
// Define FINAL_ADD_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module final_add_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [40:4] req0_prop,
  input  logic [40:4] req0_gen,
  input  logic        req0_cin,
  input  logic [40:4] req1_prop,
  input  logic [40:4] req1_gen,
  input  logic        req1_cin,
  output logic [40:4] add_prop,
  output logic [40:4] add_gen,
  output logic        add_cin,
  input  logic [41:4] add_sum,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [41:4] out_product,
  output logic        out_id,
  output logic [15:0] done_cnt
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t state, state_nxt;
  logic   can_accept;
  logic   drain;
  logic   gnt0, gnt1, grant;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (grant) state_nxt = FULL;
      FULL:    if (drain && !grant) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Output logic
  always_comb begin
    out_valid = (state == FULL);
  end

  assign drain      = out_valid && out_ready;
  assign can_accept = (state == EMPTY) || drain;

`ifdef FINAL_ADD_FIXED_PRIO_EN
  always_comb begin
    gnt0 = rst_n && can_accept && req0_valid;
    gnt1 = rst_n && can_accept && req1_valid && !req0_valid;
  end
`else
  // last_grant holds the index granted most recently; the other side wins a tie.
  logic last_grant;

  always_comb begin
    gnt0 = rst_n && can_accept && req0_valid && (!req1_valid || last_grant);
    gnt1 = rst_n && can_accept && req1_valid && (!req0_valid || !last_grant);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)     last_grant <= 1'b1;
    else if (grant) last_grant <= gnt1;
  end
`endif

  assign grant      = gnt0 || gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    add_prop = '0;
    add_gen  = '0;
    add_cin  = 1'b0;
    if (gnt0) begin
      add_prop = req0_prop;
      add_gen  = req0_gen;
      add_cin  = req0_cin;
    end else if (gnt1) begin
      add_prop = req1_prop;
      add_gen  = req1_gen;
      add_cin  = req1_cin;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_product <= '0;
      out_id      <= 1'b0;
    end else if (grant) begin
      out_product <= add_sum;
      out_id      <= gnt1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                        done_cnt <= '0;
    else if (drain && done_cnt != '1)  done_cnt <= done_cnt + 16'd1;
  end

endmodule

// File: doc/final_add_arbiter.md
FINAL_ADD_ARBITER -- requirements
Module: final_add_arbiter

Interface
REQ-001 SHALL have no parameters; all widths fixed: prop/gen bits [40:4] (37 b), product bits [41:4] (38 b).
REQ-002 SHALL have clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have req0_valid / req1_valid, input, 1 each: requester n presents an addition.
REQ-005 SHALL have req0_ready / req1_ready, output, 1 each: grant; transfer occurs when valid && ready.
REQ-006 SHALL have req0_prop, req0_gen, req1_prop, req1_gen, input, 37 each [40:4]: per-requester propagate/generate vectors.
REQ-007 SHALL have req0_cin / req1_cin, input, 1 each: per-requester carry-in.
REQ-008 SHALL have add_prop / add_gen, output, 37 [40:4], and add_cin, output, 1: drive to the shared carry-chain adder.
REQ-009 SHALL have add_sum, input, 38 [41:4]: combinational sum returned by the shared adder.
REQ-010 SHALL have out_valid, output, 1; out_ready, input, 1; out_product, output, 38 [41:4]; out_id, output, 1: registered result and source requester.
REQ-011 SHALL have done_cnt, output, 16: number of results accepted downstream.

Function
REQ-012 SHALL hold one result register with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-013 SHALL compute can_accept = EMPTY || (out_valid && out_ready); no grant when can_accept=0.
REQ-014 SHALL assert at most one reqN_ready per cycle; reqN_ready is combinational from the reqN_valid inputs, can_accept and the priority pointer.
REQ-015 SHALL grant when can_accept=1 and exactly one requester is valid: grant that requester.
REQ-016 SHALL grant when can_accept=1 and both requesters are valid: grant the requester not granted last, per the last_grant pointer.
REQ-017 SHALL update last_grant only on a cycle with a grant; idle cycles leave it unchanged.
REQ-018 SHALL drive add_prop/add_gen/add_cin from the granted requester; with no grant, all three SHALL be driven to 0.
REQ-019 SHALL on the grant edge load out_product <= add_sum, out_id <= granted index, out_valid <= 1; latency is exactly 1 cycle from grant to out_valid.
REQ-020 SHALL on out_valid && out_ready with no simultaneous grant clear out_valid; out_product and out_id hold their last values.
REQ-021 SHALL on simultaneous drain and grant keep out_valid=1 and load the new result, giving full throughput of one result per cycle.
REQ-022 SHALL hold out_product/out_id stable while out_valid && !out_ready.
REQ-023 SHALL increment done_cnt on each out_valid && out_ready, saturating at 16'hFFFF.
REQ-024 SHALL pass no carry between successive operations; each result depends only on its own request.

Reset
REQ-025 SHALL when rst_n=0 at a clock edge set: out_valid=0, out_product=0, out_id=0, done_cnt=0, last_grant=1 (requester 0 wins the first contention).
REQ-026 SHALL force req0_ready=req1_ready=0 and add_* =0 while rst_n=0.
REQ-027 SHALL discard a result held in the register if reset arrives mid-transaction; it is not counted.

Configuration
REQ-028 SHALL, with FINAL_ADD_FIXED_PRIO_EN defined, use fixed priority: requester 0 always wins contention and last_grant is unused.
REQ-029 SHALL, without FINAL_ADD_FIXED_PRIO_EN, use the round-robin arbitration of REQ-016/017.

Verification
REQ-030 SHALL cover single request: req0 prop=0x1F…F, gen=0, cin=1, adder model -> out_valid next cycle, out_product=model sum, out_id=0, done_cnt=1 after drain.
REQ-031 SHALL cover contention after reset: both valid for 4 cycles, out_ready=1 -> grants 0,1,0,1; out_id sequence 0,1,0,1 (fixed-prio build: 0,0,0,0).
REQ-032 SHALL cover backpressure: out_ready=0 for 5 cycles with both valid -> one grant only, then req*_ready=0; out_product stable; after out_ready=1 a grant occurs in the same cycle as the drain.
REQ-033 SHALL cover reset mid-operation: rst_n=0 while out_valid=1 -> next cycle out_valid=0, done_cnt=0, ready outputs 0.
REQ-034 SHALL cover saturation: preload by 65535 drains, then one more -> done_cnt stays 16'hFFFF.
REQ-035 SHALL cover idle drive: no valid for 3 cycles -> add_prop=add_gen=0, add_cin=0, last_grant unchanged.
